// File: rtl/fir_pkg.sv
// Shared types and constants for the four-tap serial FIR engine.
package fir_pkg;
    localparam int NUM_TAPS       = 4;
    localparam int COEF_FRAC_BITS = 15;
    localparam int ACC_W          = 20;
    localparam int DATA_W         = 16;

    // Bit i set means tap i is subtracted from the accumulator.
    localparam logic [NUM_TAPS-1:0] TAP_SUB = 4'b1010;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MAC,
        DONE
    } state_t;
endpackage

// File: rtl/fir_mac.sv
// Single-tap multiply-accumulate step: acc +/- ((x * c) >> 15), purely combinational.
module fir_mac
    import fir_pkg::*;
(
    input  logic [DATA_W-1:0]       x,
    input  logic [DATA_W-1:0]       c,
    input  logic signed [ACC_W-1:0] acc,
    input  logic                    sub,
    output logic signed [ACC_W-1:0] acc_next
);
    logic [2*DATA_W-1:0]      prod;
    logic [DATA_W:0]          p;
    logic signed [ACC_W-1:0]  p_ext;

    assign prod  = {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, c};
    // Q1.15 coefficient: dropping the fraction leaves at most 17 significant bits.
    assign p     = prod[2*DATA_W-1:COEF_FRAC_BITS];
    assign p_ext = {{(ACC_W-DATA_W-1){1'b0}}, p};

    assign acc_next = sub ? (acc - p_ext) : (acc + p_ext);
endmodule

// File: rtl/fir_mac_engine.sv
// Four-tap FIR engine: serial one-tap-per-cycle MAC, local coefficient cache, one-deep request buffer.
// A sample result appears 6 cycles after its pulse; modwait stays high while work is queued.
module fir_mac_engine
    import fir_pkg::*;
(
    input  logic                clk,
    input  logic                n_rst,
    input  logic [DATA_W-1:0]   sample_data,
    input  logic                data_ready,
    input  logic                new_coefficient_set,
    input  logic [DATA_W-1:0]   fir_coefficient,
    output logic [1:0]          coefficient_num,
    output logic                modwait,
    output logic [DATA_W-1:0]   fir_out,
    output logic                err
);
    state_t                          state_q, state_d;
    logic [1:0]                      tap_q, tap_d;
    logic [NUM_TAPS-1:0][DATA_W-1:0] x_q, x_d;
    logic [NUM_TAPS-1:0][DATA_W-1:0] c_q, c_d;
    logic signed [ACC_W-1:0]         acc_q, acc_d;
    logic [DATA_W-1:0]               pend_sample_q, pend_sample_d;
    logic                            pend_s_q, pend_s_d;
    logic                            pend_c_q, pend_c_d;
    logic                            modwait_q, modwait_d;
    logic [DATA_W-1:0]               fir_out_q, fir_out_d;
    logic                            err_q, err_d;

    logic                    pend_s_eff, pend_c_eff, dispatch;
    logic [DATA_W-1:0]       sample_eff;
    logic signed [ACC_W-1:0] acc_next;

    fir_mac u_mac (
        .x        (x_q[tap_q]),
        .c        (c_q[tap_q]),
        .acc      (acc_q),
        .sub      (TAP_SUB[tap_q]),
        .acc_next (acc_next)
    );

    always_comb begin
        state_d       = state_q;
        tap_d         = tap_q;
        x_d           = x_q;
        c_d           = c_q;
        acc_d         = acc_q;
        fir_out_d     = fir_out_q;
        err_d         = err_q;
        dispatch      = 1'b0;
        // This cycle's pulses count as already pending so nothing waits an extra cycle.
        pend_s_eff    = pend_s_q | data_ready;
        pend_c_eff    = pend_c_q | new_coefficient_set;
        sample_eff    = data_ready ? sample_data : pend_sample_q;
        pend_s_d      = pend_s_eff;
        pend_c_d      = pend_c_eff;
        pend_sample_d = sample_eff;

        case (state_q)
            IDLE: dispatch = 1'b1;
            LOAD: begin
                c_d[tap_q] = fir_coefficient;
                tap_d      = tap_q + 2'd1;
                dispatch   = (tap_q == 2'd3);
            end
            MAC: begin
                acc_d = acc_next;
                tap_d = tap_q + 2'd1;
                if (tap_q == 2'd3) state_d = DONE;
            end
            DONE: begin
                if (acc_q[ACC_W-1] || (|acc_q[ACC_W-2:DATA_W])) begin
                    err_d = 1'b1;
                end else begin
                    fir_out_d = acc_q[DATA_W-1:0];
                    err_d     = 1'b0;
                end
                dispatch = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Coefficient reloads win over samples so a simultaneous pair uses the new set.
        if (dispatch) begin
            if (pend_c_eff) begin
                state_d  = LOAD;
                tap_d    = 2'd0;
                pend_c_d = 1'b0;
            end else if (pend_s_eff) begin
                state_d  = MAC;
                tap_d    = 2'd0;
                acc_d    = '0;
                pend_s_d = 1'b0;
                x_d      = {x_q[NUM_TAPS-2:0], sample_eff};
            end else begin
                state_d = IDLE;
            end
        end

        modwait_d       = (state_d != IDLE);
        coefficient_num = (state_q == LOAD) ? tap_q : 2'd0;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            tap_q         <= '0;
            x_q           <= '0;
            c_q           <= '0;
            acc_q         <= '0;
            pend_sample_q <= '0;
            pend_s_q      <= 1'b0;
            pend_c_q      <= 1'b0;
            modwait_q     <= 1'b0;
            fir_out_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            tap_q         <= tap_d;
            x_q           <= x_d;
            c_q           <= c_d;
            acc_q         <= acc_d;
            pend_sample_q <= pend_sample_d;
            pend_s_q      <= pend_s_d;
            pend_c_q      <= pend_c_d;
            modwait_q     <= modwait_d;
            fir_out_q     <= fir_out_d;
            err_q         <= err_d;
        end
    end

    assign modwait = modwait_q;
    assign fir_out = fir_out_q;
    assign err     = err_q;
endmodule

// File: tb/tb_fir_mac_engine.sv
// Bench for fir_mac_engine: directed scenarios plus randomized traffic against a plain-arithmetic filter model.
module tb_fir_mac_engine;
    import fir_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [15:0] sample_data;
    logic        data_ready;
    logic        new_coefficient_set;
    logic [15:0] fir_coefficient;
    logic [1:0]  coefficient_num;
    logic        modwait;
    logic [15:0] fir_out;
    logic        err;

    logic [15:0] coef_tbl [4];
    int checks = 0;
    int errors = 0;

    // Reference model: delay line, cached coefficients and result registers as plain numbers.
    longint      m_x [4];
    longint      m_c [4];
    logic [15:0] m_fir;
    logic        m_err;

    always #5 clk = ~clk;

    assign fir_coefficient = coef_tbl[coefficient_num];

    fir_mac_engine dut (
        .clk                 (clk),
        .n_rst               (n_rst),
        .sample_data         (sample_data),
        .data_ready          (data_ready),
        .new_coefficient_set (new_coefficient_set),
        .fir_coefficient     (fir_coefficient),
        .coefficient_num     (coefficient_num),
        .modwait             (modwait),
        .fir_out             (fir_out),
        .err                 (err)
    );

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_x[i] = 0;
            m_c[i] = 0;
        end
        m_fir = '0;
        m_err = 1'b0;
    endtask

    task automatic model_load();
        for (int i = 0; i < 4; i++) m_c[i] = coef_tbl[i];
    endtask

    task automatic model_sample(input logic [15:0] s);
        longint y;
        longint p;
        m_x[3] = m_x[2];
        m_x[2] = m_x[1];
        m_x[1] = m_x[0];
        m_x[0] = s;
        y = 0;
        for (int i = 0; i < 4; i++) begin
            p = (m_x[i] * m_c[i]) / 32768;
            y = (i % 2 == 1) ? y - p : y + p;
        end
        if (y < 0 || y > 65535) begin
            m_err = 1'b1;
        end else begin
            m_fir = y[15:0];
            m_err = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_coefs(input logic [15:0] c0, input logic [15:0] c1,
                             input logic [15:0] c2, input logic [15:0] c3);
        coef_tbl[0] = c0;
        coef_tbl[1] = c1;
        coef_tbl[2] = c2;
        coef_tbl[3] = c3;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        repeat (2) tick();
        n_rst = 1'b1;
        model_reset();
    endtask

    // Pulse new_coefficient_set from idle and return at the start of cycle 5.
    task automatic run_load();
        tick();
        new_coefficient_set = 1'b1;
        tick();
        new_coefficient_set = 1'b0;
        repeat (4) tick();
        model_load();
    endtask

    // Pulse data_ready from idle and return mid-cycle 6, where the result must be visible.
    task automatic run_sample(input logic [15:0] s);
        tick();
        data_ready  = 1'b1;
        sample_data = s;
        tick();
        data_ready  = 1'b0;
        sample_data = 16'($urandom);
        repeat (5) tick();
        @(negedge clk);
        model_sample(s);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (modwait !== 1'b0 || fir_out !== 16'h0 || err !== 1'b0 || coefficient_num !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: got mw=%b fo=%h err=%b cn=%0d, expected all 0",
                     modwait, fir_out, err, coefficient_num);
        end
        set_coefs(16'h8000, 16'h0, 16'h0, 16'h0);
        run_load();
        run_sample(16'd777);
        checks++;
        if (fir_out !== 16'd777) begin
            errors++;
            $display("FAIL pre_reset_result: got %0d expected 777", fir_out);
        end
        // Start a sample and kill it in cycle 2 of its MAC.
        tick();
        data_ready  = 1'b1;
        sample_data = 16'd300;
        tick();
        data_ready  = 1'b0;
        tick();
        n_rst = 1'b0;
        #1;
        checks++;
        if (modwait !== 1'b0 || fir_out !== 16'h0 || err !== 1'b0 || coefficient_num !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_mac: got mw=%b fo=%h err=%b cn=%0d, expected all 0",
                     modwait, fir_out, err, coefficient_num);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected IDLE", dut.state_q);
        end
        tick();
        n_rst = 1'b1;
        model_reset();
        run_sample(16'd100);
        checks++;
        if (fir_out !== 16'd0 || err !== 1'b0 || modwait !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_sample: got fo=%0d err=%b mw=%b expected 0 0 0", fir_out, err, modwait);
        end
    endtask

    task automatic test_coef_load();
        do_reset();
        set_coefs(16'h8000, 16'h4000, 16'h2000, 16'h1000);
        tick();
        new_coefficient_set = 1'b1;
        tick();
        new_coefficient_set = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (coefficient_num !== 2'(k - 1) || modwait !== 1'b1) begin
                errors++;
                $display("FAIL load_cycle%0d: got cn=%0d mw=%b expected cn=%0d mw=1",
                         k, coefficient_num, modwait, k - 1);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (modwait !== 1'b0 || coefficient_num !== 2'd0) begin
            errors++;
            $display("FAIL load_end: got mw=%b cn=%0d expected mw=0 cn=0", modwait, coefficient_num);
        end
        model_load();
    endtask

    task automatic test_filter_seq();
        logic [15:0] samples [3];
        logic [15:0] expv [3];
        samples[0] = 16'd100; samples[1] = 16'd200; samples[2] = 16'd400;
        expv[0]    = 16'd100; expv[1]    = 16'd150; expv[2]    = 16'd325;
        for (int i = 0; i < 3; i++) begin
            run_sample(samples[i]);
            checks++;
            if (fir_out !== expv[i] || err !== 1'b0 || modwait !== 1'b0) begin
                errors++;
                $display("FAIL filter_seq%0d: got fo=%0d err=%b mw=%b expected fo=%0d err=0 mw=0",
                         i, fir_out, err, modwait, expv[i]);
            end
        end
    endtask

    task automatic test_underflow();
        do_reset();
        set_coefs(16'h0, 16'h8000, 16'h0, 16'h0);
        run_load();
        run_sample(16'd5);
        checks++;
        if (fir_out !== 16'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL underflow_first: got fo=%0d err=%b expected 0 0", fir_out, err);
        end
        run_sample(16'd0);
        checks++;
        if (fir_out !== 16'd0 || err !== 1'b1) begin
            errors++;
            $display("FAIL underflow_err: got fo=%0d err=%b expected fo=0 err=1", fir_out, err);
        end
    endtask

    task automatic test_overflow();
        set_coefs(16'h8000, 16'h0, 16'h0, 16'h0);
        run_load();
        run_sample(16'd1234);
        checks++;
        if (fir_out !== 16'd1234 || err !== 1'b0) begin
            errors++;
            $display("FAIL overflow_setup: got fo=%0d err=%b expected 1234 0", fir_out, err);
        end
        set_coefs(16'hFFFF, 16'h0, 16'h0, 16'h0);
        run_load();
        run_sample(16'hFFFF);
        checks++;
        if (fir_out !== 16'd1234 || err !== 1'b1) begin
            errors++;
            $display("FAIL overflow_err: got fo=%0d err=%b expected fo=1234 err=1", fir_out, err);
        end
        // 2 * 0xFFFF >> 15 = 3: an in-range result must clear err again.
        run_sample(16'd2);
        checks++;
        if (fir_out !== 16'd3 || err !== 1'b0) begin
            errors++;
            $display("FAIL overflow_recover: got fo=%0d err=%b expected 3 0", fir_out, err);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b, exp_a_fir;
        logic        exp_a_err;
        set_coefs(16'h8000, 16'h4000, 16'h2000, 16'h1000);
        run_load();
        a = 16'($urandom_range(0, 20000));
        b = 16'($urandom_range(0, 20000));
        model_sample(a);
        exp_a_fir = m_fir;
        exp_a_err = m_err;
        model_sample(b);
        tick();
        data_ready  = 1'b1;
        sample_data = a;
        tick();
        for (int cyc = 1; cyc <= 11; cyc++) begin
            data_ready  = (cyc == 2);
            sample_data = (cyc == 2) ? b : 16'($urandom);
            @(negedge clk);
            if (cyc <= 10) begin
                checks++;
                if (modwait !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_busy cycle %0d: got mw=%b expected 1", cyc, modwait);
                end
            end
            if (cyc == 6) begin
                checks++;
                if (fir_out !== exp_a_fir || err !== exp_a_err) begin
                    errors++;
                    $display("FAIL b2b_first: got fo=%0d err=%b expected fo=%0d err=%b",
                             fir_out, err, exp_a_fir, exp_a_err);
                end
            end
            if (cyc == 11) begin
                checks++;
                if (modwait !== 1'b0 || fir_out !== m_fir || err !== m_err) begin
                    errors++;
                    $display("FAIL b2b_second: got mw=%b fo=%0d err=%b expected mw=0 fo=%0d err=%b",
                             modwait, fir_out, err, m_fir, m_err);
                end
            end
            tick();
        end
        data_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [15:0] s;
        set_coefs(16'h8000, 16'h2000, 16'h4000, 16'h0800);
        s = 16'($urandom_range(1000, 30000));
        model_load();
        model_sample(s);
        tick();
        data_ready          = 1'b1;
        new_coefficient_set = 1'b1;
        sample_data         = s;
        tick();
        data_ready          = 1'b0;
        new_coefficient_set = 1'b0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cyc <= 4) begin
                checks++;
                if (coefficient_num !== 2'(cyc - 1) || dut.state_q !== LOAD) begin
                    errors++;
                    $display("FAIL simul_load cycle %0d: got cn=%0d st=%0d expected cn=%0d LOAD",
                             cyc, coefficient_num, dut.state_q, cyc - 1);
                end
            end else if (cyc <= 8) begin
                checks++;
                if (dut.state_q !== MAC) begin
                    errors++;
                    $display("FAIL simul_mac cycle %0d: got st=%0d expected MAC", cyc, dut.state_q);
                end
            end
            if (cyc <= 9) begin
                checks++;
                if (modwait !== 1'b1) begin
                    errors++;
                    $display("FAIL simul_busy cycle %0d: got mw=%b expected 1", cyc, modwait);
                end
            end else begin
                checks++;
                if (modwait !== 1'b0 || fir_out !== m_fir || err !== m_err) begin
                    errors++;
                    $display("FAIL simul_result: got mw=%b fo=%0d err=%b expected mw=0 fo=%0d err=%b",
                             modwait, fir_out, err, m_fir, m_err);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [15:0] s;
        for (int it = 0; it < 16; it++) begin
            s = 16'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < 4; i++) coef_tbl[i] = 16'($urandom_range(0, 16'h8000));
                run_load();
                run_sample(s);
                checks++;
                if (fir_out !== m_fir || err !== m_err) begin
                    errors++;
                    $display("FAIL random_sample it %0d: got fo=%0d err=%b expected fo=%0d err=%b",
                             it, fir_out, err, m_fir, m_err);
                end
            end else begin
                // Coefficient change requested during MAC must only affect later samples.
                model_sample(s);
                tick();
                data_ready  = 1'b1;
                sample_data = s;
                tick();
                data_ready = 1'b0;
                tick();
                for (int i = 0; i < 4; i++) coef_tbl[i] = 16'($urandom_range(0, 16'h8000));
                new_coefficient_set = 1'b1;
                tick();
                new_coefficient_set = 1'b0;
                repeat (6) tick();
                @(negedge clk);
                checks++;
                if (modwait !== 1'b1) begin
                    errors++;
                    $display("FAIL random_midload it %0d: got mw=%b expected 1", it, modwait);
                end
                tick();
                @(negedge clk);
                model_load();
                checks++;
                if (modwait !== 1'b0 || fir_out !== m_fir || err !== m_err) begin
                    errors++;
                    $display("FAIL random_midmac it %0d: got mw=%b fo=%0d err=%b expected mw=0 fo=%0d err=%b",
                             it, modwait, fir_out, err, m_fir, m_err);
                end
            end
        end
    endtask

    initial begin
        n_rst               = 1'b0;
        data_ready          = 1'b0;
        new_coefficient_set = 1'b0;
        sample_data         = '0;
        set_coefs(16'h0, 16'h0, 16'h0, 16'h0);
        model_reset();
        do_reset();
        test_reset();
        test_coef_load();
        test_filter_seq();
        test_underflow();
        test_overflow();
        test_back_to_back();
        test_simultaneous();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_mac_engine.md
# fir_mac_engine

- Four-tap FIR compute engine directly downstream of the AHB-Lite slave register file.
- Consumes the slave's `sample_data`/`data_ready` and `fir_coefficient`/`new_coefficient_set`.
- Returns `coefficient_num` to index the slave's coefficient registers, plus `modwait`, `fir_out` and `err` for the slave's status and result registers.
- Uses a serial, one-tap-per-cycle multiply-accumulate with a local coefficient cache and a one-deep pending-request buffer.

## Interface
Parameters: none. Widths are fixed: 16-bit data, 4 taps.
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- sample_data  in  16  new sample; valid in the cycle `data_ready` is high
- data_ready  in  1  single-cycle pulse: a new sample was written
- new_coefficient_set  in  1  single-cycle pulse: the coefficient set was updated
- fir_coefficient  in  16  coefficient selected by `coefficient_num`; combinational from upstream, same cycle
- coefficient_num  out  2  coefficient index requested from upstream
- modwait  out  1  registered; high while the engine is busy
- fir_out  out  16  last valid filter result
- err  out  1  last computation was out of range

## Operation
- State register: IDLE, LOAD, MAC, DONE. A 2-bit `tap` counter is shared by LOAD and MAC.
- **Request capture**
  - A `data_ready` pulse in any state latches `sample_data` into `pend_sample` and sets `pend_s`.
  - A later pulse overwrites `pend_sample`; no error is raised.
  - A `new_coefficient_set` pulse sets `pend_c`.
  - Pulses seen in IDLE are serviced immediately, exactly as if they were pending.
- **Dispatch** in IDLE, or on leaving LOAD or DONE:
  - `pend_c` goes to LOAD, `tap`=0.
  - Otherwise `pend_s` goes to MAC, `tap`=0, and the sample is shifted in: x3←x2, x2←x1, x1←x0, x0←`pend_sample`.
  - Otherwise go to IDLE.
  - Clear each pending flag on the same edge that dispatches it. If no request is dispatched, `modwait` falls on that edge.
- **LOAD**
  - `coefficient_num` = `tap`.
  - Each edge stores `c[tap]` ← `fir_coefficient`, then `tap`++.
  - After `tap`=3, dispatch.
  - Outside LOAD, `coefficient_num` = 0.
- **MAC**
  - Each cycle: p = (x[tap] × c[tap]) >> 15, a 32-bit unsigned product truncated to 17 bits.
  - acc ± p: even taps add, odd taps subtract, so y = p0 − p1 + p2 − p3.
  - acc is 20-bit signed and cleared on entry to MAC.
  - After `tap`=3, go to DONE.
- **DONE**
  - If acc < 0 or acc > 0xFFFF: `err`←1 and `fir_out` holds its previous value.
  - Otherwise: `fir_out`←acc[15:0] and `err`←0.
  - Then dispatch.
- Coefficients are unsigned Q1.15 (0x8000 = 1.0). Samples are unsigned.
- A coefficient update during MAC takes effect on the next sample, not the one in flight.

## Timing
- A pulse in cycle 0 while IDLE makes `modwait` high from cycle 1.
- Load: LOAD occupies cycles 1–4 with `coefficient_num` = 0,1,2,3. `modwait` is low in cycle 5 if nothing is pending.
- Sample: MAC occupies cycles 1–4 and DONE cycle 5. New `fir_out`/`err` are visible and `modwait` is low in cycle 6. Latency is 6 cycles.
- Back-to-back pending work: `modwait` stays high continuously with no idle cycle inserted.
- Simultaneous `data_ready` and `new_coefficient_set`: the load runs first, then the sample.
- Reset, including mid-operation, aborts all work and forces:
  - state IDLE;
  - x0–x3, c0–c3, acc, pend_sample = 0;
  - pend_s, pend_c = 0;
  - `modwait`, `err`, `fir_out`, `coefficient_num` = 0.

## Structure
- **Package `fir_pkg`:**
  - state enum (IDLE, LOAD, MAC, DONE);
  - `NUM_TAPS` = 4;
  - `COEF_FRAC_BITS` = 15;
  - `ACC_W` = 20;
  - tap sign pattern `TAP_SUB` = 4'b1010.
- **Sub-module `fir_mac`**, combinational:
  - inputs x, c, acc, sub;
  - output acc_next = acc ± ((x × c) >> 15).
- The FSM, counters, pending buffer, delay line and coefficient cache stay in the top.

## Test plan
1. **Reset:** assert n_rst mid-MAC → all outputs 0 and state IDLE. A following `data_ready` with 100 and zero coefficients → `fir_out` = 0, `err` = 0 at cycle 6.
2. **Coefficient load:** bench drives `fir_coefficient` by index {0x8000, 0x4000, 0x2000, 0x1000} and pulses `new_coefficient_set` → `coefficient_num` 0,1,2,3 in cycles 1–4, `modwait` high in cycles 1–4 and low in cycle 5.
3. **Filter sequence** with those coefficients: samples 100, 200, 400 → `fir_out` 100, then 150, then 325, each in cycle 6 after its pulse.
4. **Underflow:** coefficients {0, 0x8000, 0, 0}, samples 5 then 0 → `fir_out` = 0 with `err` = 0, then `err` = 1 with `fir_out` still 0.
5. **Overflow:** coefficients {0xFFFF, 0, 0, 0}, sample 0xFFFF → p0 = 0x1FFFC, `err` = 1, `fir_out` unchanged.
6. **Concurrency:**
   - `data_ready` in cycle 2 of a MAC → second result follows with no `modwait` gap.
   - Simultaneous `new_coefficient_set` and `data_ready` in IDLE → LOAD in cycles 1–4, MAC in cycles 5–8, result in cycle 10.
